ps2_cmd_seq: RTL and testbench
==============================

# ps2_cmd_seq

Host-side PS/2 command sequencer sitting directly upstream of the PS/2 host transmitter and alongside the PS/2 receiver. It accepts a command byte with an optional argument byte, for example keyboard LED set 0xED + mask, or mouse 0xF4. It issues each byte to the transmitter, waits for the transmitter's completion, then waits for the device's acknowledge (0xFA) on the receiver stream. Resend, timeout and error reporting are handled here, so the host logic sees one done or error pulse per command.

## Interface
- TIMEOUT_W, 24: width of the per-byte timeout counter; timeout = 2^TIMEOUT_W − 1 clk cycles.
- MAX_RETRY, 3: maximum retransmissions per byte after a 0xFE reply (2-bit counter, 0–3).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_byte  in  8  command byte.
- arg_en  in  1  command carries an argument byte.
- arg_byte  in  8  argument byte.
- cmd_ready  out  1  high only in IDLE; the handshake completes when cmd_valid & cmd_ready.
- wr_ps2  out  1  one-cycle write strobe to the transmitter.
- tx_data  out  8  byte presented to the transmitter (registered).
- tx_idle  in  1  transmitter idle.
- tx_done_tick  in  1  transmitter frame complete.
- rx_done_tick  in  1  receiver byte valid.
- rx_data  in  8  received byte.
- busy  out  1  high whenever state ≠ IDLE.
- done_tick  out  1  one-cycle pulse: command (and argument, if any) acknowledged.
- err_tick  out  1  one-cycle pulse: command aborted.
- err_code  out  2  held from err_tick until the next accepted command; 00 none, 01 timeout, 10 resend limit or resend rejected.

## Operation
- The state machine has five states: IDLE, SEND, WAIT_TX, WAIT_ACK, DONE.
- IDLE:
  - On handshake, latch cmd_byte, arg_byte and arg_en.
  - Clear phase (0 = command, 1 = argument), the retry count and err_code.
  - Go to SEND.
- SEND:
  - Wait for tx_idle = 1.
  - Then drive tx_data = phase ? arg : cmd, pulse wr_ps2 for exactly one cycle, load the timeout counter with all ones, and go to WAIT_TX.
- WAIT_TX:
  - The counter decrements each cycle.
  - On tx_done_tick, go to WAIT_ACK; the counter is not reloaded, so the timeout covers transmit plus acknowledge.
  - If the counter reaches 0 first, raise error 01.
- WAIT_ACK:
  - rx_done_tick with rx_data = 0xFA: if phase = 0 and arg = 1, set phase = 1, clear the retry count and go to SEND; otherwise go to DONE.
  - rx_data = 0xFE: resend handling, see Configuration.
  - Any other byte is ignored and waiting continues.
  - Counter reaching 0: raise error 01.
- DONE: pulse done_tick for one cycle, then return to IDLE.
- Error path: pulse err_tick for one cycle, set err_code, return to IDLE. The latched bytes are discarded.
- The argument byte is sent only after the command's 0xFA.

## Timing
- Reset values:
  - state IDLE; cmd_ready = 1, busy = 0.
  - wr_ps2 = 0, tx_data = 0x00.
  - done_tick = 0, err_tick = 0, err_code = 00.
  - Counters = 0.
- Latencies:
  - Handshake to wr_ps2: 1 cycle if tx_idle is already high (SEND is entered on the next edge, and the strobe is issued in that state).
  - Final 0xFA rx_done_tick to done_tick: 1 cycle.
  - wr_ps2 is never asserted while tx_idle = 0.
- Simultaneous events:
  - rx_done_tick during WAIT_TX or SEND is ignored.
  - In WAIT_ACK, an rx_done_tick arriving in the same cycle the counter hits 0 takes priority over the timeout.
  - tx_done_tick and a counter hitting 0 in the same cycle: tx_done_tick wins.
- cmd_valid while busy: ignored, since cmd_ready = 0; no queuing.
- Reset asserted mid-command: immediate return to IDLE with reset values. No strobe or tick is emitted on release.

## Configuration
- PS2_CMD_SEQ_RESEND_EN defined:
  - 0xFE in WAIT_ACK with retry count < MAX_RETRY increments the count and returns to SEND, retransmitting the same byte with a fresh timeout.
  - When the count equals MAX_RETRY, raise error 10.
- Not defined: any 0xFE raises error 10 immediately. The retry counter and MAX_RETRY logic are omitted.

## Test plan
- cmd 0xF4, arg_en = 0, tx_idle = 1; model returns tx_done_tick, then rx 0xFA → exactly one wr_ps2 with tx_data = 0xF4, then done_tick 1 cycle after the 0xFA; err_tick never high.
- cmd 0xED with arg 0x07; reply 0xFA, then 0xFA → two wr_ps2 strobes carrying 0xED then 0x07; a single done_tick after the second ACK.
- cmd 0xFF; device replies 0xAA, then 0xFA → 0xAA is ignored; done_tick follows 0xFA.
- RESEND_EN defined, MAX_RETRY = 3, device always replies 0xFE → 4 strobes of the same byte, then err_tick with err_code = 10. With the macro undefined: 1 strobe, then immediate err_code = 10.
- TIMEOUT_W = 8, no rx response → err_tick with err_code = 01 exactly 255 cycles after wr_ps2; cmd_ready back to 1 on the next cycle.
- Reset pulsed during WAIT_ACK, then 0xFA received after release → no done_tick; outputs at reset values; a new command is accepted normally.

Source files
------------

// File: rtl/ps2_cmd_seq.sv
// Host-side PS/2 command sequencer: sends a command byte (plus optional argument), waits for 0xFA.
// Optional retransmission on 0xFE is enabled with `define PS2_CMD_SEQ_RESEND_EN.
//
// state    | meaning
// IDLE     | waiting for a command handshake
// SEND     | waiting for tx_idle, then strobing the current byte
// WAIT_TX  | transmitter busy, timeout running
// WAIT_ACK | waiting for the device's 0xFA / 0xFE, timeout still running
// DONE     | one-cycle done_tick, back to IDLE
module ps2_cmd_seq #(
  parameter int TIMEOUT_W = 24
`ifdef PS2_CMD_SEQ_RESEND_EN
  , parameter int MAX_RETRY = 3
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  input  logic       arg_en,
  input  logic [7:0] arg_byte,
  output logic       cmd_ready,
  output logic       wr_ps2,
  output logic [7:0] tx_data,
  input  logic       tx_idle,
  input  logic       tx_done_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       busy,
  output logic       done_tick,
  output logic       err_tick,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_ACK, DONE} state_t;

  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_RESEND  = 2'b10;

  state_t               state_q, state_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [7:0]           arg_q, arg_d;
  logic                 arg_en_q, arg_en_d;
  logic                 phase_q, phase_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [1:0]           err_now;
  logic                 expire;
  logic                 rx_ack, rx_resend;
`ifdef PS2_CMD_SEQ_RESEND_EN
  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);
  logic [1:0]           retry_q, retry_d;
`endif

  // The counter expires on the cycle it would step from 1 to 0, so a full
  // load gives exactly 2^TIMEOUT_W-1 waiting cycles after the strobe.
  assign expire    = (cnt_q[TIMEOUT_W-1:1] == '0);
  assign rx_ack    = rx_done_tick && (rx_data == BYTE_ACK);
  assign rx_resend = rx_done_tick && (rx_data == BYTE_RESEND);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      arg_q      <= 8'h00;
      arg_en_q   <= 1'b0;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      err_code_q <= 2'b00;
`ifdef PS2_CMD_SEQ_RESEND_EN
      retry_q    <= 2'b00;
`endif
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      arg_q      <= arg_d;
      arg_en_q   <= arg_en_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
`ifdef PS2_CMD_SEQ_RESEND_EN
      retry_q    <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    arg_d      = arg_q;
    arg_en_d   = arg_en_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    err_code_d = err_code_q;
`ifdef PS2_CMD_SEQ_RESEND_EN
    retry_d    = retry_q;
`endif
    wr_ps2     = 1'b0;
    done_tick  = 1'b0;
    err_tick   = 1'b0;
    err_now    = 2'b00;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tx_data_d  = cmd_byte;
          arg_d      = arg_byte;
          arg_en_d   = arg_en;
          phase_d    = 1'b0;
          err_code_d = 2'b00;
`ifdef PS2_CMD_SEQ_RESEND_EN
          retry_d    = 2'b00;
`endif
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_idle) begin
          wr_ps2  = 1'b1;
          cnt_d   = '1;
          state_d = WAIT_TX;
        end
      end
      WAIT_TX: begin
        cnt_d = cnt_q - TIMEOUT_W'(1);
        if (tx_done_tick) begin
          state_d = WAIT_ACK;
        end else if (expire) begin
          err_tick = 1'b1;
          err_now  = ERR_TIMEOUT;
        end
      end
      WAIT_ACK: begin
        cnt_d = cnt_q - TIMEOUT_W'(1);
        if (rx_ack) begin
          if (!phase_q && arg_en_q) begin
            phase_d   = 1'b1;
            tx_data_d = arg_q;
`ifdef PS2_CMD_SEQ_RESEND_EN
            retry_d   = 2'b00;
`endif
            state_d   = SEND;
          end else begin
            state_d = DONE;
          end
        end else if (rx_resend) begin
`ifdef PS2_CMD_SEQ_RESEND_EN
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 2'd1;
            state_d = SEND;
          end else begin
            err_tick = 1'b1;
            err_now  = ERR_RESEND;
          end
`else
          err_tick = 1'b1;
          err_now  = ERR_RESEND;
`endif
        end else if (expire) begin
          err_tick = 1'b1;
          err_now  = ERR_TIMEOUT;
        end
      end
      DONE: begin
        done_tick = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err_tick) begin
      err_code_d = err_now;
      arg_d      = 8'h00;
      arg_en_d   = 1'b0;
      phase_d    = 1'b0;
      state_d    = IDLE;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign tx_data   = tx_data_q;
  // The code is visible in the same cycle as err_tick, then held by the register.
  assign err_code  = err_tick ? err_now : err_code_q;

endmodule

// File: tb/tb_ps2_cmd_seq.sv
// Scoreboard bench for ps2_cmd_seq: a reference model predicts strobes and results,
// a device model answers the strobes, and a monitor pops and compares.
module tb_ps2_cmd_seq;

  localparam int TW      = 8;
  localparam int RETRIES = 3;
`ifdef PS2_CMD_SEQ_RESEND_EN
  localparam bit RESEND_EN = 1'b1;
`else
  localparam bit RESEND_EN = 1'b0;
`endif

  localparam int P_RAND  = 0;
  localparam int P_ACK   = 1;
  localparam int P_NAK   = 2;
  localparam int P_NONE  = 3;
  localparam int P_JUNK  = 4;
  localparam int P_RESET = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       arg_en = 1'b0;
  logic [7:0] arg_byte = 8'h00;
  logic       cmd_ready, wr_ps2, busy, done_tick, err_tick;
  logic [7:0] tx_data;
  logic [1:0] err_code;
  logic       tx_idle = 1'b1;
  logic       tx_done_tick = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;

  ps2_cmd_seq #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .arg_en(arg_en), .arg_byte(arg_byte),
    .cmd_ready(cmd_ready), .wr_ps2(wr_ps2), .tx_data(tx_data),
    .tx_idle(tx_idle), .tx_done_tick(tx_done_tick),
    .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .busy(busy), .done_tick(done_tick), .err_tick(err_tick), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int exp_tx[$];
  int exp_res[$];
  int reply_q[$];
  bit go_fa = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  int  last_strobe = -1000, last_fa = -1000, last_fe = -1000, hs_cyc = -1000;
  bit  ready_next = 1'b0;
  int  mon_e, mon_kind;
  always @(negedge clk) begin
    if (!reset) begin
      if (ready_next) begin
        check("ready_after_result", int'(cmd_ready), 1);
        ready_next = 1'b0;
      end
      if (cyc == hs_cyc + 1) begin
        check("err_code_cleared", int'(err_code), 0);
        if (tx_idle) check("hs_to_strobe_latency", int'(wr_ps2), 1);
      end
      if (cmd_valid && cmd_ready) hs_cyc = cyc;
      if (rx_done_tick && rx_data == 8'hFA) last_fa = cyc;
      if (rx_done_tick && rx_data == 8'hFE) last_fe = cyc;
      if (wr_ps2) begin
        check("strobe_while_tx_idle", int'(tx_idle), 1);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: tx_data 0x%0h, no strobe expected", tx_data);
        end else begin
          mon_e = exp_tx.pop_front();
          check("tx_data", int'(tx_data), mon_e);
          last_strobe = cyc;
        end
      end
      if (done_tick || err_tick) begin
        check("tick_exclusive", int'(done_tick & err_tick), 0);
        mon_kind = done_tick ? 0 : int'(err_code);
        if (done_tick) check("done_err_code", int'(err_code), 0);
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: kind %0d, no result expected", mon_kind);
        end else begin
          mon_e = exp_res.pop_front();
          check("result_kind", mon_kind, mon_e);
          if (mon_e == 0) check("done_latency", cyc - last_fa, 1);
          if (mon_e == 1) check("timeout_cycles", cyc - last_strobe, 255);
          if (mon_e == 2) check("resend_err_latency", cyc - last_fe, 0);
          ready_next = 1'b1;
        end
      end
    end
  end

  // Device / transmitter model: answers each strobe with the scripted reply.
  int dev_r, dev_k;
  initial begin
    forever begin
      @(negedge clk);
      if (wr_ps2 && !reset) begin
        dev_r = (reply_q.size() != 0) ? reply_q.pop_front() : -1;
        step(1);
        tx_idle = 1'b0;
        step($urandom_range(1, 5));
        tx_done_tick = 1'b1;
        step(1);
        tx_done_tick = 1'b0;
        if (dev_r == -2) begin
          tx_idle = 1'b1;
          dev_k = 0;
          while (!go_fa && dev_k < 500) begin step(1); dev_k++; end
          if (!go_fa) begin
            checks++; errors++;
            $display("FAIL device_wait: go_fa never raised within %0d cycles", dev_k);
          end else begin
            rx_data = 8'hFA; rx_done_tick = 1'b1;
            step(1);
            rx_done_tick = 1'b0;
          end
        end else if (dev_r == -1) begin
          step($urandom_range(1, 3));
          tx_idle = 1'b1;
        end else begin
          step($urandom_range(1, 4));
          if (dev_r[8]) begin
            rx_data = 8'($urandom_range(0, 8'hF9)); rx_done_tick = 1'b1;
            step(1);
            rx_done_tick = 1'b0;
            step($urandom_range(1, 3));
          end
          rx_data = dev_r[7:0]; rx_done_tick = 1'b1;
          step(1);
          rx_done_tick = 1'b0;
          if ($urandom_range(0, 1) == 0) step($urandom_range(1, 3));
          tx_idle = 1'b1;
        end
      end
    end
  end

  // Reference model: predicts the strobe sequence and final outcome of one command.
  // Result kinds: 0 done, 1 timeout, 2 resend failure, -1 none (aborted by reset).
  task automatic issue(input int cmd, input bit aen, input int arg, input int policy,
                       output int res);
    int bytes[2];
    int r, n, tries;
    bit stop;
    bytes[0] = cmd;
    bytes[1] = arg;
    res  = 0;
    stop = 1'b0;
    for (int i = 0; i < (aen ? 2 : 1) && !stop; i++) begin
      tries = 0;
      forever begin
        exp_tx.push_back(bytes[i]);
        case (policy)
          P_ACK:   r = 'hFA;
          P_NAK:   r = 'hFE;
          P_NONE:  r = -1;
          P_JUNK:  r = 'h1FA;
          P_RESET: r = -2;
          default: begin
            n = $urandom_range(0, 9);
            r = (n < 7) ? 'hFA : (n < 9) ? 'hFE : -1;
            if (r > 0 && $urandom_range(0, 3) == 0) r = r | 'h100;
          end
        endcase
        reply_q.push_back(r);
        if (r == -2) begin res = -1; stop = 1'b1; break; end
        if (r == -1) begin res = 1; stop = 1'b1; break; end
        if ((r & 'hFF) == 'hFE) begin
          if (RESEND_EN && tries < RETRIES) begin tries++; continue; end
          res = 2; stop = 1'b1; break;
        end
        break;
      end
    end
    if (res >= 0) exp_res.push_back(res);
    step(1);
    cmd_valid = 1'b1; cmd_byte = 8'(cmd); arg_en = aen; arg_byte = 8'(arg);
    step(1);
    cmd_valid = 1'b0; cmd_byte = 8'($urandom); arg_en = 1'($urandom); arg_byte = 8'($urandom);
  endtask

  task automatic finish_cmd(input int res);
    int k;
    k = 0;
    while (exp_res.size() != 0 && k < 3000) begin @(negedge clk); k++; end
    if (exp_res.size() != 0) begin
      checks++; errors++;
      $display("FAIL result_wait: no result after %0d cycles, expected kind %0d", k, exp_res[0]);
      exp_res.delete();
    end
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    check("cmd_ready_return", int'(cmd_ready), 1);
    check("strobes_remaining", exp_tx.size(), 0);
    exp_tx.delete();
    if (res > 0) check("err_code_held", int'(err_code), res);
    k = 0;
    while (!tx_idle && k < 20) begin @(negedge clk); k++; end
  endtask

  task automatic check_reset_values();
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_wr_ps2", int'(wr_ps2), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_done_tick", int'(done_tick), 0);
    check("rst_err_tick", int'(err_tick), 0);
    check("rst_err_code", int'(err_code), 0);
  endtask

  int res;
  initial begin
    @(negedge clk);
    check_reset_values();
    step(3);
    reset = 1'b0;
    step(2);

    issue('hF4, 1'b0, 'h00, P_ACK, res);  finish_cmd(res);
    issue('hED, 1'b1, 'h07, P_ACK, res);  finish_cmd(res);
    issue('hFF, 1'b0, 'h00, P_JUNK, res); finish_cmd(res);
    issue('hF3, 1'b1, 'h0A, P_NAK, res);  finish_cmd(res);
    issue('hF2, 1'b0, 'h00, P_NONE, res); finish_cmd(res);

    // Reset while waiting for the acknowledge; the late 0xFA must produce nothing.
    issue('h55, 1'b0, 'h00, P_RESET, res);
    step(12);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values();
    step(1);
    reset = 1'b0;
    go_fa = 1'b1;
    step(10);
    go_fa = 1'b0;
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_strobes", exp_tx.size(), 0);
    exp_tx.delete();
    reply_q.delete();

    issue('hF4, 1'b0, 'h00, P_ACK, res); finish_cmd(res);

    for (int i = 0; i < 40; i++) begin
      issue($urandom_range(0, 255), 1'($urandom_range(0, 1)), $urandom_range(0, 255), P_RAND, res);
      finish_cmd(res);
    end

    step(5);
    check("final_result_queue", exp_res.size(), 0);
    check("final_reply_queue", reply_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
